// File: rtl/vga_timing_gen.sv
// vga_timing_gen: registered VGA raster timing (counters, sync, data-valid, frame pulse).
// Optional colour-bar source is built only when the macro TEST_PATTERN_EN is defined.
module vga_timing_gen #(
  parameter int HRES   = 1600,
  parameter int VRES   = 900,
  parameter int H_FP   = 24,
  parameter int H_SYNC = 80,
  parameter int H_BP   = 96,
  parameter int V_FP   = 1,
  parameter int V_SYNC = 3,
  parameter int V_BP   = 96,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [10:0] h_cnt,
  output logic [10:0] v_cnt,
  output logic        vga_dv_o,
  output logic        vga_hs_o,
  output logic        vga_vs_o,
  output logic        frame_start_o,
  output logic [7:0]  tb_red_i,
  output logic [7:0]  tb_green_i,
  output logic [7:0]  tb_blue_i
);

  localparam int H_TOT    = HRES + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = VRES + V_FP + V_SYNC + V_BP;
  localparam int HS_START = HRES + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = VRES + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam logic [10:0] H_LAST = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOT - 1);

  if (H_TOT > 2048) begin : g_h_tot_too_big
    $fatal(1, "vga_timing_gen: H_TOT exceeds the 11-bit counter range");
  end
  if (V_TOT > 2048) begin : g_v_tot_too_big
    $fatal(1, "vga_timing_gen: V_TOT exceeds the 11-bit counter range");
  end

  // Cleared by reset so the first enabled edge presents pixel (0,0) instead of advancing past it.
  logic        started_r;
  logic [10:0] h_nxt_s;
  logic [10:0] v_nxt_s;
  logic        dv_nxt_s;
  logic        hs_nxt_s;
  logic        vs_nxt_s;
  logic        fs_nxt_s;
  logic [23:0] rgb_nxt_s;

  // Next raster position.
  always_comb begin
    h_nxt_s = 11'd0;
    v_nxt_s = 11'd0;
    if (started_r) begin
      if (h_cnt == H_LAST) begin
        h_nxt_s = 11'd0;
        if (v_cnt == V_LAST) begin
          v_nxt_s = 11'd0;
        end else begin
          v_nxt_s = v_cnt + 11'd1;
        end
      end else begin
        h_nxt_s = h_cnt + 11'd1;
        v_nxt_s = v_cnt;
      end
    end else begin
      h_nxt_s = 11'd0;
      v_nxt_s = 11'd0;
    end
  end

  // Region decode of the next position, so every registered output describes the same pixel.
  always_comb begin
    dv_nxt_s = (int'(h_nxt_s) < HRES) && (int'(v_nxt_s) < VRES);
    fs_nxt_s = (h_nxt_s == 11'd0) && (v_nxt_s == 11'd0);
    if ((int'(h_nxt_s) >= HS_START) && (int'(h_nxt_s) < HS_END)) begin
      hs_nxt_s = HS_POL;
    end else begin
      hs_nxt_s = ~HS_POL;
    end
    // v only changes when h wraps, so vs edges land on h = 0.
    if ((int'(v_nxt_s) >= VS_START) && (int'(v_nxt_s) < VS_END)) begin
      vs_nxt_s = VS_POL;
    end else begin
      vs_nxt_s = ~VS_POL;
    end
  end

`ifdef TEST_PATTERN_EN
  function automatic logic [23:0] bar_colour(input logic [2:0] bar);
    logic [23:0] rgb;
    case (bar)
      3'd0:    rgb = 24'hFFFFFF;
      3'd1:    rgb = 24'hFFFF00;
      3'd2:    rgb = 24'h00FFFF;
      3'd3:    rgb = 24'h00FF00;
      3'd4:    rgb = 24'hFF00FF;
      3'd5:    rgb = 24'hFF0000;
      3'd6:    rgb = 24'h0000FF;
      3'd7:    rgb = 24'h000000;
      default: rgb = 24'h000000;
    endcase
    return rgb;
  endfunction

  logic [13:0] h_scaled_s;
  logic [2:0]  bar_s;

  // Bar index = h * 8 / HRES; colour only inside the active window.
  always_comb begin
    h_scaled_s = {h_nxt_s, 3'b000};
    bar_s      = 3'(int'(h_scaled_s) / HRES);
    if (dv_nxt_s) begin
      rgb_nxt_s = bar_colour(bar_s);
    end else begin
      rgb_nxt_s = 24'h000000;
    end
  end
`else
  assign rgb_nxt_s = 24'h000000;
`endif

  // Output and counter registers; en low holds everything, including a pending frame pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started_r     <= 1'b0;
      h_cnt         <= 11'd0;
      v_cnt         <= 11'd0;
      vga_dv_o      <= 1'b0;
      vga_hs_o      <= ~HS_POL;
      vga_vs_o      <= ~VS_POL;
      frame_start_o <= 1'b0;
      tb_red_i      <= 8'h00;
      tb_green_i    <= 8'h00;
      tb_blue_i     <= 8'h00;
    end else if (en) begin
      started_r     <= 1'b1;
      h_cnt         <= h_nxt_s;
      v_cnt         <= v_nxt_s;
      vga_dv_o      <= dv_nxt_s;
      vga_hs_o      <= hs_nxt_s;
      vga_vs_o      <= vs_nxt_s;
      frame_start_o <= fs_nxt_s;
      tb_red_i      <= rgb_nxt_s[23:16];
      tb_green_i    <= rgb_nxt_s[15:8];
      tb_blue_i     <= rgb_nxt_s[7:0];
    end
  end

endmodule
